// File: rtl/multiport_regfile_sb.sv
// Multi-read-port integer register file with a destination scoreboard, hazard output and pending counter.
// Optional write-to-read forwarding and same-cycle hazard release: define RF_BYPASS_EN.
module multiport_regfile_sb #(
  parameter  int unsigned XLEN = 32,
  parameter  int unsigned NREG = 32,
  parameter  int unsigned NRD  = 2,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_idx,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_idx,
  output logic                hazard,
  output logic [AW:0]         pending_cnt
);

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0]     regs_q [NREG];
  logic [NREG-1:0]     busy_q, busy_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0]       rd_sel_c [NRD];
  logic [NRD-1:0]      raw_c;
  logic                wr_act_c, iss_act_c, set_c, clr_c, waw_c;

  // Scoreboard next state; a set on the same index as a clear wins
  always_comb begin
    wr_act_c  = wr_en && (wr_idx != '0);
    iss_act_c = issue_en && (issue_idx != '0);
    set_c     = iss_act_c && !busy_q[issue_idx];
    clr_c     = wr_act_c && busy_q[wr_idx] && !(iss_act_c && (issue_idx == wr_idx));
    busy_d    = busy_q;
    if (wr_act_c) busy_d[wr_idx] = 1'b0;
    if (iss_act_c) busy_d[issue_idx] = 1'b1;
    cnt_d = cnt_q + {{AW{1'b0}}, set_c} - {{AW{1'b0}}, clr_c};
  end

  // Read mux, forwarding and RAW/WAW detection
  always_comb begin
    rd_data_d = '0;
    raw_c     = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_sel_c[k] = rd_idx[k*AW +: AW];
    end
    for (int unsigned k = 0; k < NRD; k++) begin
      if (BYPASS && wr_act_c && (wr_idx == rd_sel_c[k])) begin
        rd_data_d[k*XLEN +: XLEN] = wr_data;
      end else begin
        rd_data_d[k*XLEN +: XLEN] = regs_q[rd_sel_c[k]];
      end
      raw_c[k] = (rd_sel_c[k] != '0) && busy_q[rd_sel_c[k]] &&
                 !(BYPASS && wr_act_c && (wr_idx == rd_sel_c[k]));
    end
    waw_c  = iss_act_c && busy_q[issue_idx] &&
             !(BYPASS && wr_act_c && (wr_idx == issue_idx));
    hazard = (|raw_c) || waw_c;
  end

  // All state advances on the falling edge of clk
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_act_c) regs_q[wr_idx] <= wr_data;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Self-checking bench for multiport_regfile_sb: default 2-port build plus a 4-port/16-reg/64-bit instance.
module tb_multiport_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_idx;
  logic        hazard;
  logic [5:0]  pending_cnt;

  logic [15:0]  rd_idx4;
  logic [255:0] rd_data4;
  logic         wr_en4;
  logic [3:0]   wr_idx4;
  logic [63:0]  wr_data4;
  logic         issue_en4;
  logic [3:0]   issue_idx4;
  logic         hazard4;
  logic [4:0]   pending_cnt4;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic [31:0] sb_q [$];
  logic        hz_seen;
  logic        hz4_seen;
  logic [63:0] pat [4];

  multiport_regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .issue_en(issue_en), .issue_idx(issue_idx),
    .hazard(hazard), .pending_cnt(pending_cnt)
  );

  multiport_regfile_sb #(.XLEN(64), .NREG(16), .NRD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx4), .rd_data(rd_data4),
    .wr_en(wr_en4), .wr_idx(wr_idx4), .wr_data(wr_data4),
    .issue_en(issue_en4), .issue_idx(issue_idx4),
    .hazard(hazard4), .pending_cnt(pending_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_busy = '0;
  endtask

  // One cycle on the 2-port instance; entered and left at posedge+1
  task automatic cyc(input logic [4:0] r0, input logic [4:0] r1,
                     input logic we, input logic [4:0] wi, input logic [31:0] wd,
                     input logic ie, input logic [4:0] ii);
    logic [4:0]  rs [2];
    logic        exp_hz;
    logic        byp;
    logic [31:0] exp_rd;
    rd_idx = {r1, r0}; wr_en = we; wr_idx = wi; wr_data = wd;
    issue_en = ie; issue_idx = ii;
    #1;
    byp = 1'b0;
`ifdef RF_BYPASS_EN
    byp = 1'b1;
`endif
    rs[0] = r0; rs[1] = r1;
    exp_hz = 1'b0;
    for (int k = 0; k < 2; k++)
      if (rs[k] != 0 && m_busy[rs[k]] && !(byp && we && wi == rs[k])) exp_hz = 1'b1;
    if (ie && ii != 0 && m_busy[ii] && !(byp && we && wi == ii)) exp_hz = 1'b1;
    hz_seen = hazard;
    chk("hazard", 64'(hazard), 64'(exp_hz));
    for (int k = 0; k < 2; k++)
      sb_q.push_back((byp && we && wi != 0 && wi == rs[k]) ? wd : m_reg[rs[k]]);
    if (we && wi != 0) begin
      m_reg[wi]  = wd;
      m_busy[wi] = 1'b0;
    end
    if (ie && ii != 0) m_busy[ii] = 1'b1;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      exp_rd = sb_q.pop_front();
      chk($sformatf("rd_data%0d", k), 64'(rd_data[k*32 +: 32]), 64'(exp_rd));
    end
    chk("pending_cnt", 64'(pending_cnt), 64'($countones(m_busy)));
    @(posedge clk); #1;
  endtask

  // One cycle on the 4-port instance; checks are done by the caller
  task automatic cyc4(input logic [15:0] r, input logic we, input logic [3:0] wi,
                      input logic [63:0] wd, input logic ie, input logic [3:0] ii);
    rd_idx4 = r; wr_en4 = we; wr_idx4 = wi; wr_data4 = wd;
    issue_en4 = ie; issue_idx4 = ii;
    #1;
    hz4_seen = hazard4;
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    rd_idx = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; issue_en = 1'b0; issue_idx = '0;
    rd_idx4 = '0; wr_en4 = 1'b0; wr_idx4 = '0; wr_data4 = '0; issue_en4 = 1'b0; issue_idx4 = '0;
    pat[0] = 64'h0123_4567_89AB_CDEF;
    pat[1] = 64'hFEDC_BA98_7654_3210;
    pat[2] = 64'hDEAD_BEEF_CAFE_F00D;
    pat[3] = 64'h8000_0000_0000_0001;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_pending", 64'(pending_cnt), 64'h0);
    chk("rst_hazard", 64'(hazard), 64'h0);
    chk("rst_pending4", 64'(pending_cnt4), 64'h0);
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then dual read of x7; x0 stays zero
    cyc(0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
    cyc(7, 7, 0, 0, 0, 0, 0);
    chk("rd7_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("rd7_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    cyc(0, 0, 1, 0, 32'h1234, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rd_x0", 64'(rd_data[31:0]), 64'h0);

    // RAW on x3, retired by a write
    cyc(0, 0, 0, 0, 0, 1, 3);
    chk("raw_pending", 64'(pending_cnt), 64'h1);
    cyc(3, 0, 0, 0, 0, 0, 0);
    chk("raw_hz", 64'(hz_seen), 64'h1);
    cyc(3, 0, 1, 3, 32'h55, 0, 0);
`ifdef RF_BYPASS_EN
    chk("retire_hz", 64'(hz_seen), 64'h0);
    chk("retire_fwd", 64'(rd_data[31:0]), 64'h55);
`else
    chk("retire_hz", 64'(hz_seen), 64'h1);
    chk("retire_old", 64'(rd_data[31:0]), 64'h0);
    cyc(3, 0, 0, 0, 0, 0, 0);
    chk("after_hz", 64'(hz_seen), 64'h0);
    chk("after_rd", 64'(rd_data[31:0]), 64'h55);
`endif

    // Same-edge set and clear of x4: set wins
    cyc(0, 0, 0, 0, 0, 1, 4);
    cyc(0, 0, 1, 4, 32'h99, 1, 4);
    chk("setclr_pending", 64'(pending_cnt), 64'h1);
    cyc(4, 0, 0, 0, 0, 0, 0);
    chk("setclr_hz", 64'(hz_seen), 64'h1);
    cyc(0, 0, 1, 4, 32'h9A, 0, 0);

    // Different indices on the same edge both apply
    cyc(0, 0, 0, 0, 0, 1, 5);
    cyc(0, 0, 1, 5, 32'h5, 1, 6);
    chk("diff_pending", 64'(pending_cnt), 64'h1);
    cyc(0, 6, 1, 6, 32'h6, 0, 0);

    // Fill the scoreboard, WAW re-issue, drain, spurious write
    for (int i = 1; i < 32; i++) cyc(0, 0, 0, 0, 0, 1, 5'(i));
    chk("full_pending", 64'(pending_cnt), 64'd31);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("waw_hz", 64'(hz_seen), 64'h1);
    chk("waw_pending", 64'(pending_cnt), 64'd31);
    for (int i = 1; i < 32; i++) cyc(5'(i), 5'(32 - i), 1, 5'(i), 32'(i) * 32'h0101_0101, 0, 0);
    chk("drain_pending", 64'(pending_cnt), 64'h0);
    cyc(9, 0, 1, 9, 32'hABCD, 0, 0);
    chk("spur_pending", 64'(pending_cnt), 64'h0);

    // Asynchronous reset in the middle of traffic
    cyc(0, 0, 0, 0, 0, 1, 2);
    cyc(0, 0, 1, 5, 32'hABC, 0, 0);
    cyc(5, 0, 0, 0, 0, 0, 0);
    rd_idx = {5'd5, 5'd2}; issue_en = 1'b1; issue_idx = 5'd6;
    #1;
    chk("pre_rst_hz", 64'(hazard), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", rd_data, 64'h0);
    chk("mid_rst_pending", 64'(pending_cnt), 64'h0);
    chk("mid_rst_hz", 64'(hazard), 64'h0);
    rd_idx = '0; issue_en = 1'b0; issue_idx = '0;
    model_reset();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(5, 0, 0, 0, 0, 0, 0);
    chk("post_rst_x5", 64'(rd_data[31:0]), 64'h0);

    // 4-port, 16-entry, 64-bit instance
    for (int k = 0; k < 4; k++) cyc4(16'h0, 1, 4'(k + 1), pat[k], 0, 0);
    cyc4(16'h4321, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("w4_rd%0d", k), rd_data4[k*64 +: 64], pat[k]);
    chk("w4_hz_idle", 64'(hz4_seen), 64'h0);
    cyc4(16'h0, 0, 0, 0, 1, 4);
    chk("w4_pending", 64'(pending_cnt4), 64'h1);
    cyc4(16'h4321, 0, 0, 0, 0, 0);
    chk("w4_hz_p3", 64'(hz4_seen), 64'h1);
    cyc4(16'h0321, 0, 0, 0, 0, 0);
    chk("w4_hz_p012", 64'(hz4_seen), 64'h0);
    cyc4(16'h4000, 0, 0, 0, 0, 0);
    chk("w4_hz_only3", 64'(hz4_seen), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
